// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the IF/ID record type for the LEGv8 pipeline.
package pipe_pkg;

  // AArch64 NOP encoding, used as the bubble instruction.
  localparam logic [31:0] NOP = 32'hD503201F;

  // Register-index field positions inside an instruction word.
  localparam int RN_LSB    = 5;
  localparam int RM_LSB    = 16;
  localparam int REG_IDX_W = 5;

  // IF/ID contents at the default 64-bit PC / 32-bit instruction widths.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async reset, load enable, synchronous flush.
// Flush has priority over enable so a squash cannot be blocked by a stall.
module pipe_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] flush_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register with priority reset > flush > enable > hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (flush) begin
      q <= flush_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, and saturating
// stall/flush event counters for debug.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_write,
  input  logic                 ifid_write,
  input  logic                 br_taken,
  input  logic [PC_W-1:0]      br_target,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic [PC_W-1:0]      ifid_pc,
  output logic [INSTR_W-1:0]   ifid_instr,
  output logic                 ifid_valid,
  output logic [REG_IDX_W-1:0] ifid_rn,
  output logic [REG_IDX_W-1:0] ifid_rm,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int                 IFID_W   = PC_W + INSTR_W + 1;
  localparam logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP);
  localparam logic [IFID_W-1:0]  IFID_RST = {{PC_W{1'b0}}, NOP_WORD, 1'b0};

  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   pc_next;
  logic [IFID_W-1:0] ifid_d;
  logic [IFID_W-1:0] ifid_flush_val;
  logic [IFID_W-1:0] ifid_q;

  // Branch targets are word aligned; the two low bits are discarded.
  logic [1:0] tgt_low_unused;
  assign tgt_low_unused = br_target[1:0];

  // Next PC: taken branch beats stall, otherwise advance by one word.
  always_comb begin
    pc_next = pc_reg;
    if (br_taken) begin
      pc_next = {br_target[PC_W-1:2], 2'b00};
    end else if (pc_write) begin
      pc_next = pc_reg + PC_W'(4);
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign imem_addr = pc_reg;

  // A flush still records the current PC so the bubble carries a sensible PC.
  assign ifid_d         = {pc_reg, imem_data, 1'b1};
  assign ifid_flush_val = {pc_reg, NOP_WORD, 1'b0};

  pipe_reg #(
    .W       (IFID_W),
    .RST_VAL (IFID_RST)
  ) u_ifid (
    .clk       (clk),
    .reset     (reset),
    .en        (ifid_write),
    .flush     (br_taken),
    .flush_val (ifid_flush_val),
    .d         (ifid_d),
    .q         (ifid_q)
  );

  assign ifid_pc    = ifid_q[IFID_W-1 -: PC_W];
  assign ifid_instr = ifid_q[INSTR_W:1];
  assign ifid_valid = ifid_q[0];

  // Register fields for the hazard unit come straight off the IF/ID register.
  assign ifid_rn = ifid_instr[RN_LSB +: REG_IDX_W];
  assign ifid_rm = ifid_instr[RM_LSB +: REG_IDX_W];

  // Event qualifiers: a branch during a stall counts only as a flush.
  logic [1:0]       cnt_event;
  logic [CNT_W-1:0] cnt_reg [2];

  assign cnt_event[0] = !pc_write && !br_taken;
  assign cnt_event[1] = br_taken;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      // Saturating event counter.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_event[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign stall_cnt = cnt_reg[0];
  assign flush_cnt = cnt_reg[1];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage LEGv8 pipeline. Holds the program counter, drives the instruction-memory address, and latches the fetched instruction and its PC into the IF/ID register. It is the direct upstream producer for the hazard-detection unit: it supplies the decoded Rn/Rm fields and honours that unit's PC-write and IF/ID-write stall controls. It also squashes the wrong-path instruction on a taken branch and keeps saturating stall/flush event counters for debug.

## Interface
- PC_W, 64, program-counter width.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0, PC value loaded on reset.
- CNT_W, 16, width of the stall and flush event counters.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_write  in  1  1 = PC may advance; 0 = hold PC (stall).
- ifid_write  in  1  1 = IF/ID register may load; 0 = hold IF/ID (stall).
- br_taken  in  1  branch resolved taken in EX this cycle.
- br_target  in  PC_W  branch destination, valid when br_taken = 1.
- imem_addr  out  PC_W  instruction-memory address; always equals the current PC.
- imem_data  in  INSTR_W  instruction word, combinationally valid for imem_addr in the same cycle.
- ifid_pc  out  PC_W  PC of the instruction held in IF/ID.
- ifid_instr  out  INSTR_W  instruction held in IF/ID.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble/NOP).
- ifid_rn  out  5  ifid_instr[9:5], fed to the hazard unit.
- ifid_rm  out  5  ifid_instr[20:16], fed to the hazard unit.
- stall_cnt  out  CNT_W  cycles in which pc_write = 0 and br_taken = 0; saturates at all-ones.
- flush_cnt  out  CNT_W  cycles in which br_taken = 1; saturates at all-ones.

## Operation
- PC update priority, highest first:
  - reset: PC = RESET_PC.
  - br_taken: PC = {br_target[PC_W-1:2], 2'b00}. The low two bits are forced to zero.
  - !pc_write: PC holds.
  - Otherwise PC = PC + 4, wrapping modulo 2^PC_W with no flag.
- IF/ID update priority, highest first:
  - reset: ifid_pc = 0, ifid_instr = NOP, ifid_valid = 0.
  - br_taken: flush. ifid_instr = NOP and ifid_valid = 0; ifid_pc = current PC. Flush overrides ifid_write = 0.
  - !ifid_write: all IF/ID fields hold.
  - Otherwise ifid_pc = PC, ifid_instr = imem_data, ifid_valid = 1.
- pc_write and ifid_write are independent. pc_write = 0 with ifid_write = 1 re-latches the same instruction; this is legal and not an error.
- ifid_rn and ifid_rm are pure slices of the registered ifid_instr; no extra latency.
- Counters:
  - reset clears both to 0.
  - Each increments by 1 per qualifying cycle and holds at 2^CNT_W − 1.
  - A cycle with br_taken = 1 and pc_write = 0 counts only as a flush.

## Timing
- Fetch latency: the instruction at address A appears on ifid_instr one rising edge after PC = A, provided there is no stall or flush.
- Stall: each cycle with pc_write = 0 and ifid_write = 0 adds exactly one cycle of latency; outputs are unchanged during it.
- Taken branch asserted in cycle N:
  - at edge N+1, PC = target and IF/ID = bubble;
  - at edge N+2, the target instruction is in IF/ID.
- Reset is asynchronous: assertion forces every output to its reset value immediately, including mid-stall or mid-flush. After deassertion, the first edge latches the instruction at RESET_PC.
- Reset values: imem_addr = RESET_PC, ifid_pc = 0, ifid_instr = NOP, ifid_valid = 0, ifid_rn = NOP[9:5], ifid_rm = NOP[20:16], stall_cnt = 0, flush_cnt = 0.
- No combinational path from any input to any output, except imem_addr, which is driven directly by the PC register.

## Structure
- Package pipe_pkg contains:
  - NOP = 32'hD503201F;
  - RN_LSB = 5, RM_LSB = 16, REG_IDX_W = 5;
  - the typedef ifid_t, a struct of pc, instr and valid.
- Sub-module pipe_reg: a parameterised-width register with async active-high reset, load enable, and a synchronous flush that loads a supplied flush value (flush beats enable). Instantiated once for the IF/ID register and reused later for ID/EX.
- The PC register and the counters live directly in fetch_stage.

## Test plan
- Sequential fetch: release reset with RESET_PC = 0, hold pc_write = ifid_write = 1 for 4 cycles. Required response: imem_addr = 0, 4, 8, 12; ifid_pc lags by one cycle; ifid_valid = 1 from the first edge.
- Load-use stall: PC = 0x10, drive pc_write = ifid_write = 0 for 2 cycles. Required response: PC stays 0x10, IF/ID holds, stall_cnt = 2; fetch resumes at 0x14.
- Branch during stall: pc_write = ifid_write = 0, br_taken = 1, br_target = 0x103. Required response: PC = 0x100, ifid_valid = 0, ifid_instr = NOP, flush_cnt = 1, stall_cnt unchanged.
- Rn/Rm decode: imem_data = 32'h8B020020 (ADD X0, X1, X2). Required response: next cycle ifid_rn = 1, ifid_rm = 2.
- Wrap and saturation: PC = 64'hFFFF_FFFF_FFFF_FFFC advances to 0. With CNT_W = 4, 20 stall cycles leave stall_cnt = 15.
- Async reset mid-flush: assert reset between edges during a taken branch. Required response: outputs take reset values before the next edge.
